// File: rtl/wb_rr_arbiter_if.sv
// Wishbone B3 signal bundle between MASTERS requesters, the round-robin arbiter and
// the single downstream slave path.
//   slave  : the arbiter's view (it is the slave of the requesters, master of the bus)
//   master : the environment's view (requesters plus the downstream slave)
interface wb_rr_arbiter_if #(
  parameter int MASTERS = 2
);
  logic [32*MASTERS-1:0] m_adr_i;
  logic [32*MASTERS-1:0] m_dat_i;
  logic [4*MASTERS-1:0]  m_sel_i;
  logic [MASTERS-1:0]    m_cyc_i;
  logic [MASTERS-1:0]    m_stb_i;
  logic [MASTERS-1:0]    m_we_i;
  logic [32*MASTERS-1:0] m_dat_o;
  logic [MASTERS-1:0]    m_ack_o;
  logic [MASTERS-1:0]    m_err_o;
  logic [31:0]           s_adr_o;
  logic [31:0]           s_dat_o;
  logic [3:0]            s_sel_o;
  logic                  s_we_o;
  logic                  s_cyc_o;
  logic                  s_stb_o;
  logic [31:0]           s_dat_i;
  logic                  s_ack_i;
  logic                  s_err_i;
  logic [MASTERS-1:0]    grant_o;

  modport slave (
    input  m_adr_i, m_dat_i, m_sel_i, m_cyc_i, m_stb_i, m_we_i,
    input  s_dat_i, s_ack_i, s_err_i,
    output m_dat_o, m_ack_o, m_err_o,
    output s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o,
    output grant_o
  );

  modport master (
    output m_adr_i, m_dat_i, m_sel_i, m_cyc_i, m_stb_i, m_we_i,
    output s_dat_i, s_ack_i, s_err_i,
    input  m_dat_o, m_ack_o, m_err_o,
    input  s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o,
    input  grant_o
  );
endinterface

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone B3 arbiter: shares one slave-side path between MASTERS requesters.
// Ownership is taken at a registered edge and held for the whole cyc, so bursts and
// read-modify-write sequences stay atomic. While granted, the slave path is a purely
// combinational mux of the owner's signals.
// Optional build macro WB_ARB_TIMEOUT_EN adds a watchdog that ends a hung access with err
// after TIMEOUT_CYCLES unanswered strobe cycles.
module wb_rr_arbiter #(
  parameter int MASTERS        = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic           clk_i,
  input  logic           rst_i,
  wb_rr_arbiter_if.slave bus
);

  localparam int PW = (MASTERS > 1) ? $clog2(MASTERS) : 1;

  // Reject illegal configurations at elaboration time.
  if (MASTERS < 2 || MASTERS > 8) begin : g_bad_masters
    $error("wb_rr_arbiter: MASTERS must be 2..8");
  end
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("wb_rr_arbiter: TIMEOUT_CYCLES must be 2..65535");
  end

`ifdef WB_ARB_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, ERR = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1} state_t;
`endif

  state_t             state_q, state_d;
  logic [MASTERS-1:0] grant_q, grant_d;
  logic [PW-1:0]      owner_q, owner_d;
  logic [PW-1:0]      last_q,  last_d;
  logic               timeout_hit;

  // Per-master views of the packed address/data/select buses.
  logic [31:0] adr_a [MASTERS];
  logic [31:0] dat_a [MASTERS];
  logic [3:0]  sel_a [MASTERS];

  for (genvar i = 0; i < MASTERS; i++) begin : g_unpack
    assign adr_a[i] = bus.m_adr_i[32*i +: 32];
    assign dat_a[i] = bus.m_dat_i[32*i +: 32];
    assign sel_a[i] = bus.m_sel_i[4*i +: 4];
  end

  // Read data goes to every slot; only the owner sees ack/err, so others ignore it.
  assign bus.m_dat_o = {MASTERS{bus.s_dat_i}};
  assign bus.grant_o = grant_q;

  // First requester found searching upward from last+1, wrapping at MASTERS-1.
  function automatic logic [PW-1:0] pick_next(input logic [MASTERS-1:0] req,
                                               input logic [PW-1:0]      last);
    logic [PW-1:0] win;
    logic [PW-1:0] cand;
    logic          found;
    win   = last;
    found = 1'b0;
    for (int k = 1; k <= MASTERS; k++) begin
      cand = PW'((int'(last) + k) % MASTERS);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    return win;
  endfunction

`ifdef WB_ARB_TIMEOUT_EN
  logic [15:0] wd_cnt_q;

  // Terminal watchdog cycle: owner strobing, slave silent, count at its last value.
  // A slave ack/err in that same cycle wins and the access ends normally.
  assign timeout_hit = (state_q == GRANT) && bus.m_stb_i[owner_q] &&
                       !bus.s_ack_i && !bus.s_err_i &&
                       (wd_cnt_q == 16'(TIMEOUT_CYCLES - 1));

  // Watchdog counter: runs only across unanswered strobe cycles of the owner.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wd_cnt_q <= '0;
    end else if (state_q != GRANT || !bus.m_stb_i[owner_q] || bus.s_ack_i || bus.s_err_i) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_q + 16'd1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Arbitration state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      last_q  <= PW'(MASTERS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  // Next-state: grant on request from IDLE, release when the owner drops cyc.
  always_comb begin
    // NOTE: every output of this block is defaulted first so no latch is inferred.
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (|bus.m_cyc_i) begin
          owner_d = pick_next(bus.m_cyc_i, last_q);
          grant_d = MASTERS'(1) << owner_d;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!bus.m_cyc_i[owner_q]) begin
          state_d = IDLE;
          grant_d = '0;
          last_d  = owner_q;
        end else if (timeout_hit) begin
`ifdef WB_ARB_TIMEOUT_EN
          state_d = ERR;
`endif
        end
      end
`ifdef WB_ARB_TIMEOUT_EN
      ERR: begin
        if (!bus.m_cyc_i[owner_q]) begin
          state_d = IDLE;
          grant_d = '0;
          last_d  = owner_q;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Slave-side mux and owner ack/err routing; everything idles at 0.
  always_comb begin
    bus.s_adr_o = '0;
    bus.s_dat_o = '0;
    bus.s_sel_o = '0;
    bus.s_we_o  = 1'b0;
    bus.s_cyc_o = 1'b0;
    bus.s_stb_o = 1'b0;
    bus.m_ack_o = '0;
    bus.m_err_o = '0;
    if (state_q == GRANT) begin
      bus.s_adr_o          = adr_a[owner_q];
      bus.s_dat_o          = dat_a[owner_q];
      bus.s_sel_o          = sel_a[owner_q];
      bus.s_we_o           = bus.m_we_i[owner_q];
      bus.s_cyc_o          = bus.m_cyc_i[owner_q];
      bus.s_stb_o          = bus.m_stb_i[owner_q];
      bus.m_ack_o[owner_q] = bus.s_ack_i;
      bus.m_err_o[owner_q] = bus.s_err_i | timeout_hit;
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter (two masters): directed multi-cycle sequences,
// a table of mux vectors, and randomized traffic against a behavioural ownership model.
module tb_wb_rr_arbiter;

  localparam int M  = 2;
  localparam int TO = 16;

  logic clk_i;
  logic rst_i;

  wb_rr_arbiter_if #(.MASTERS(M)) bus ();

  wb_rr_arbiter #(.MASTERS(M), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, got stuck expected finish");
    $fatal(1, "global timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven from here.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_m(input int m, input logic cyc, input logic stb, input logic we,
                       input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    bus.m_cyc_i[m]         = cyc;
    bus.m_stb_i[m]         = stb;
    bus.m_we_i[m]          = we;
    bus.m_adr_i[32*m +: 32] = adr;
    bus.m_dat_i[32*m +: 32] = dat;
    bus.m_sel_i[4*m +: 4]  = sel;
  endtask

  task automatic idle_inputs();
    bus.m_adr_i = '0;
    bus.m_dat_i = '0;
    bus.m_sel_i = '0;
    bus.m_cyc_i = '0;
    bus.m_stb_i = '0;
    bus.m_we_i  = '0;
    bus.s_dat_i = '0;
    bus.s_ack_i = 1'b0;
    bus.s_err_i = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
  endtask

  typedef struct {
    logic [31:0] adr0, adr1, dat1, sdat;
    logic [3:0]  sel1;
    logic        stb0, stb1, we1, ack, err;
    logic [31:0] e_adr, e_dat;
    logic [3:0]  e_sel;
    logic        e_we, e_stb;
    logic [1:0]  e_ack, e_err;
  } vec_t;

  vec_t vecs [6];

  // Behavioural model state for the randomized phase.
  int          owner;
  int          last;
  logic        r_cyc [M];
  logic        r_stb [M];
  logic        r_we  [M];
  logic [31:0] r_adr [M];
  logic [31:0] r_dat [M];
  logic [3:0]  r_sel [M];

  initial begin
    int          order[$];
    logic [M-1:0] prev_g;
    logic [M-1:0] drop;
    bit          gap_ok;
    int          errs_seen;
    int          wait_cnt;
    logic        ack_r, err_r;
    logic [31:0] sdat_r;
    logic [M-1:0] e_grant, e_ack, e_err;
    logic        e_cyc, e_stb;
    logic [31:0] e_adr;

    vecs[0] = '{adr0:32'hAAAA0000, adr1:32'h00001000, dat1:32'h11111111, sdat:32'h0, sel1:4'hF,
                stb0:1, stb1:1, we1:1, ack:0, err:0,
                e_adr:32'h00001000, e_dat:32'h11111111, e_sel:4'hF, e_we:1, e_stb:1, e_ack:2'b00, e_err:2'b00};
    vecs[1] = '{adr0:32'hAAAA0000, adr1:32'h00001000, dat1:32'h11111111, sdat:32'h0, sel1:4'hF,
                stb0:1, stb1:1, we1:1, ack:1, err:0,
                e_adr:32'h00001000, e_dat:32'h11111111, e_sel:4'hF, e_we:1, e_stb:1, e_ack:2'b10, e_err:2'b00};
    vecs[2] = '{adr0:32'hBBBB0000, adr1:32'h00002000, dat1:32'h22222222, sdat:32'h0, sel1:4'h3,
                stb0:1, stb1:0, we1:0, ack:0, err:1,
                e_adr:32'h00002000, e_dat:32'h22222222, e_sel:4'h3, e_we:0, e_stb:0, e_ack:2'b00, e_err:2'b10};
    vecs[3] = '{adr0:32'h0, adr1:32'hFFFFFFFC, dat1:32'h33333333, sdat:32'h0, sel1:4'h8,
                stb0:0, stb1:1, we1:1, ack:1, err:1,
                e_adr:32'hFFFFFFFC, e_dat:32'h33333333, e_sel:4'h8, e_we:1, e_stb:1, e_ack:2'b10, e_err:2'b10};
    vecs[4] = '{adr0:32'h12340000, adr1:32'h00000040, dat1:32'h0, sdat:32'h12345678, sel1:4'h1,
                stb0:1, stb1:1, we1:0, ack:1, err:0,
                e_adr:32'h00000040, e_dat:32'h0, e_sel:4'h1, e_we:0, e_stb:1, e_ack:2'b10, e_err:2'b00};
    vecs[5] = '{adr0:32'hFFFFFFFF, adr1:32'h0, dat1:32'h0, sdat:32'hA5A5A5A5, sel1:4'h0,
                stb0:1, stb1:1, we1:0, ack:0, err:0,
                e_adr:32'h0, e_dat:32'h0, e_sel:4'h0, e_we:0, e_stb:1, e_ack:2'b00, e_err:2'b00};

    // ---- Reset held with every master requesting
    rst_i = 1'b1;
    idle_inputs();
    for (int m = 0; m < M; m++) set_m(m, 1, 1, 1, 32'h10 * m, 32'h0, 4'hF);
    bus.s_ack_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      #2;
      check("reset_grant", bus.grant_o, 0);
      check("reset_s_cyc", bus.s_cyc_o, 0);
      check("reset_m_ack", bus.m_ack_o, 0);
    end

    // ---- Single write from master 0, slave acks two cycles after grant
    do_reset();
    set_m(0, 1, 1, 1, 32'h100, 32'hDEADBEEF, 4'hF);
    #2;
    check("wr_grant_before_edge", bus.grant_o, 0);
    check("wr_s_cyc_before_edge", bus.s_cyc_o, 0);
    tick(); #2;
    check("wr_grant", bus.grant_o, 2'b01);
    check("wr_s_adr", bus.s_adr_o, 32'h100);
    check("wr_s_dat", bus.s_dat_o, 32'hDEADBEEF);
    check("wr_s_sel", bus.s_sel_o, 4'hF);
    check("wr_s_we_cyc_stb", {bus.s_we_o, bus.s_cyc_o, bus.s_stb_o}, 3'b111);
    check("wr_no_ack_yet", bus.m_ack_o, 0);
    tick(); #2;
    check("wr_no_ack_wait", bus.m_ack_o, 0);
    tick();
    bus.s_ack_i = 1'b1;
    #2;
    check("wr_ack", bus.m_ack_o, 2'b01);
    tick();
    bus.s_ack_i = 1'b0;
    set_m(0, 0, 0, 0, 32'h100, 32'hDEADBEEF, 4'hF);
    #2;
    check("wr_ack_one_cycle", bus.m_ack_o, 0);
    check("wr_grant_until_edge", bus.grant_o, 2'b01);
    tick(); #2;
    check("wr_release_grant", bus.grant_o, 0);
    check("idle_s_adr", bus.s_adr_o, 0);
    check("idle_s_dat_sel_we", {bus.s_dat_o, bus.s_sel_o, bus.s_we_o}, 0);

    // ---- Both masters request continuously, one access each per ownership
    do_reset();
    set_m(0, 1, 1, 0, 32'h0000A000, 32'h0, 4'hF);
    set_m(1, 1, 1, 0, 32'h0000B000, 32'h0, 4'hF);
    prev_g = '0;
    drop   = '0;
    gap_ok = 1'b1;
    for (int c = 0; c < 40 && order.size() < 4; c++) begin
      for (int m = 0; m < M; m++) begin
        bus.m_cyc_i[m] = !drop[m];
        bus.m_stb_i[m] = !drop[m];
      end
      #1 bus.s_ack_i = bus.s_cyc_o & bus.s_stb_o;
      #1;
      if (bus.grant_o != '0 && bus.grant_o != prev_g) begin
        if (prev_g != '0) gap_ok = 1'b0;
        order.push_back(bus.grant_o[1] ? 1 : 0);
      end
      prev_g = bus.grant_o;
      drop   = bus.m_ack_o;
      tick();
    end
    bus.s_ack_i = 1'b0;
    check("rr_grant_count", order.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("rr_order_%0d", i), (order.size() > i) ? order[i] : -1, i % 2);
    check("rr_dead_cycle_between_owners", gap_ok, 1'b1);

    // ---- Master 0 holds cyc over three accesses; master 1 waits
    do_reset();
    set_m(0, 1, 0, 0, 32'h200, 32'h0, 4'hF);
    set_m(1, 1, 1, 1, 32'h0000C000, 32'h5, 4'hF);
    tick(); #2;
    check("hold_first_grant", bus.grant_o, 2'b01);
    for (int a = 0; a < 3; a++) begin
      tick();
      set_m(0, 1, 1, 0, 32'h200 + 32'(4 * a), 32'h0, 4'hF);
      bus.s_ack_i = 1'b1;
      #2;
      check($sformatf("hold_ack_%0d", a), bus.m_ack_o, 2'b01);
      check($sformatf("hold_adr_%0d", a), bus.s_adr_o, 32'h200 + 32'(4 * a));
      tick();
      bus.m_stb_i[0] = 1'b0;
      bus.s_ack_i    = 1'b0;
      #2;
      check($sformatf("hold_grant_gap_%0d", a), bus.grant_o, 2'b01);
    end
    bus.m_cyc_i[0] = 1'b0;
    tick(); #2;
    check("hold_dead_cycle", bus.grant_o, 0);
    tick(); #2;
    check("hold_m1_granted", bus.grant_o, 2'b10);
    check("hold_m1_adr", bus.s_adr_o, 32'h0000C000);

    // ---- Table of mux vectors while master 1 owns and master 0 stalls
    do_reset();
    set_m(1, 1, 1, 0, 32'h0, 32'h0, 4'h0);
    tick();
    bus.m_cyc_i[0] = 1'b1;
    #2;
    check("tbl_grant", bus.grant_o, 2'b10);
    for (int i = 0; i < 6; i++) begin
      tick();
      set_m(0, 1, vecs[i].stb0, 1, vecs[i].adr0, ~vecs[i].dat1, 4'hF);
      set_m(1, 1, vecs[i].stb1, vecs[i].we1, vecs[i].adr1, vecs[i].dat1, vecs[i].sel1);
      bus.s_ack_i = vecs[i].ack;
      bus.s_err_i = vecs[i].err;
      bus.s_dat_i = vecs[i].sdat;
      #2;
      check($sformatf("tbl%0d_adr", i), bus.s_adr_o, vecs[i].e_adr);
      check($sformatf("tbl%0d_dat", i), bus.s_dat_o, vecs[i].e_dat);
      check($sformatf("tbl%0d_sel_we_stb", i), {bus.s_sel_o, bus.s_we_o, bus.s_stb_o},
            {vecs[i].e_sel, vecs[i].e_we, vecs[i].e_stb});
      check($sformatf("tbl%0d_ack", i), bus.m_ack_o, vecs[i].e_ack);
      check($sformatf("tbl%0d_err", i), bus.m_err_o, vecs[i].e_err);
      check($sformatf("tbl%0d_mdat", i), bus.m_dat_o, {2{vecs[i].sdat}});
    end

    // ---- Silent slave
    do_reset();
    set_m(0, 1, 1, 0, 32'h400, 32'h0, 4'hF);
    set_m(1, 1, 1, 0, 32'h500, 32'h0, 4'hF);
    tick();
`ifdef WB_ARB_TIMEOUT_EN
    for (int n = 1; n <= TO; n++) begin
      #2;
      check($sformatf("wd_err_cycle_%0d", n), bus.m_err_o, (n == TO) ? 2'b01 : 2'b00);
      tick();
    end
    #2;
    check("wd_s_cyc_stb_forced", {bus.s_cyc_o, bus.s_stb_o}, 2'b00);
    check("wd_err_single_pulse", bus.m_err_o, 0);
    check("wd_grant_held", bus.grant_o, 2'b01);
    bus.m_cyc_i[0] = 1'b0;
    bus.m_stb_i[0] = 1'b0;
    tick(); #2;
    check("wd_release", bus.grant_o, 0);
    tick(); #2;
    check("wd_m1_granted", bus.grant_o, 2'b10);
`else
    errs_seen = 0;
    for (int n = 0; n < 40; n++) begin
      #2;
      if (bus.m_err_o != '0) errs_seen++;
      tick();
    end
    #2;
    check("silent_no_err", errs_seen, 0);
    check("silent_still_waiting", {bus.s_cyc_o, bus.s_stb_o, bus.grant_o}, 4'b1101);
`endif

    // ---- Reset pulsed in the middle of a read wait
    do_reset();
    set_m(0, 1, 1, 0, 32'h300, 32'h0, 4'hF);
    bus.s_dat_i = 32'hCAFEF00D;
    tick(); #2;
    check("rd_grant", bus.grant_o, 2'b01);
    check("rd_mdat", bus.m_dat_o, {2{32'hCAFEF00D}});
    tick();
    rst_i       = 1'b1;
    bus.s_ack_i = 1'b1;
    #1;
    check("rd_rst_s_cyc", bus.s_cyc_o, 0);
    check("rd_rst_grant", bus.grant_o, 0);
    check("rd_rst_no_ack", bus.m_ack_o, 0);
    tick(); #2;
    check("rd_rst_held", {bus.grant_o, bus.s_cyc_o, bus.m_ack_o}, 0);
    bus.s_ack_i = 1'b0;

    // ---- Randomized traffic against the ownership model
    do_reset();
    owner    = -1;
    last     = M - 1;
    wait_cnt = 0;
    for (int m = 0; m < M; m++) r_cyc[m] = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      for (int m = 0; m < M; m++) begin
        if (r_cyc[m]) begin
          if ($urandom_range(7) == 0) r_cyc[m] = 1'b0;
        end else if ($urandom_range(2) == 0) begin
          r_cyc[m] = 1'b1;
        end
        r_stb[m] = r_cyc[m] & $urandom_range(1);
        r_we[m]  = $urandom_range(1);
        r_adr[m] = $urandom;
        r_dat[m] = $urandom;
        r_sel[m] = 4'($urandom_range(15));
        set_m(m, r_cyc[m], r_stb[m], r_we[m], r_adr[m], r_dat[m], r_sel[m]);
      end
      e_stb  = (owner >= 0) && r_stb[owner];
      ack_r  = ($urandom_range(2) == 0) || (e_stb && wait_cnt >= 5);
      err_r  = ($urandom_range(15) == 0);
      sdat_r = $urandom;
      bus.s_ack_i = ack_r;
      bus.s_err_i = err_r;
      bus.s_dat_i = sdat_r;

      e_grant = (owner >= 0) ? (M'(1) << owner) : '0;
      e_cyc   = (owner >= 0) && r_cyc[owner];
      e_adr   = (owner >= 0) ? r_adr[owner] : 32'h0;
      e_ack   = ack_r ? e_grant : '0;
      e_err   = err_r ? e_grant : '0;
      #2;
      check("rnd_grant", bus.grant_o, e_grant);
      check("rnd_s_cyc_stb", {bus.s_cyc_o, bus.s_stb_o}, {e_cyc, e_stb});
      check("rnd_s_adr", bus.s_adr_o, e_adr);
      check("rnd_m_ack", bus.m_ack_o, e_ack);
      check("rnd_m_err", bus.m_err_o, e_err);
      check("rnd_m_dat", bus.m_dat_o, {2{sdat_r}});

      wait_cnt = (e_stb && !ack_r && !err_r) ? wait_cnt + 1 : 0;
      if (owner < 0) begin
        for (int k = 1; k <= M; k++) begin
          if (owner < 0 && r_cyc[(last + k) % M]) owner = (last + k) % M;
        end
        wait_cnt = 0;
      end else if (!r_cyc[owner]) begin
        last     = owner;
        owner    = -1;
        wait_cnt = 0;
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
